// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage, feeds the IF/ID register.
//   Owns the PC and fetches over a req/ack handshake with variable latency.
//   A one-entry hold buffer absorbs a response that lands while the pipeline
//   is frozen. Branch redirects from EXE abandon an in-flight request by
//   "killing" it: the request stays on the bus until acked, then is dropped.
// Ports:
//   clk, rst (sync, active-low)
//   freeze                     stall from ID, outputs hold
//   branch_taken, branch_addr  redirect from EXE
//   imem_req/imem_addr         fetch request, held until imem_ack
//   imem_ack/imem_rdata        one-cycle response strobe and data
//   pc_out/instruction_out/valid_out   to IF/ID
// Optional: define IF_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic {FETCH, FULL} state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] kill_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        accept;   // response is real and belongs to the current pc

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    always_comb begin
        imem_req   = (state == FETCH);
        imem_addr  = kill ? kill_addr : pc;
        accept     = imem_req && imem_ack && !kill && !branch_taken;
        state_next = state;
        if (branch_taken)
            state_next = FETCH;
        else if (state == FETCH && accept && freeze)
            state_next = FULL;
        else if (state == FULL && !freeze)
            state_next = FETCH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc              <= RESET_PC;
            kill            <= 1'b0;
            kill_addr       <= 32'h0;
            hold_pc         <= 32'h0;
            hold_instr      <= 32'h0;
            pc_out          <= 32'h0;
            instruction_out <= 32'h0;
            valid_out       <= 1'b0;
        end else if (branch_taken) begin
            pc              <= branch_addr;
            instruction_out <= 32'h0;
            valid_out       <= 1'b0;
            // The bus address must not change while a request is pending, so
            // remember it and discard its response when it arrives. If a kill
            // is already pending, its address stays; an ack this cycle ends it.
            if (kill) begin
                if (imem_ack) kill <= 1'b0;
            end else if (imem_req && !imem_ack) begin
                kill      <= 1'b1;
                kill_addr <= imem_addr;
            end
        end else if (state == FETCH) begin
            if (imem_ack && kill) begin
                kill <= 1'b0;
                if (!freeze) begin
                    instruction_out <= 32'h0;
                    valid_out       <= 1'b0;
                end
            end else if (accept) begin
                pc <= pc + PC_STEP;
                if (freeze) begin
                    hold_pc    <= pc + PC_STEP;
                    hold_instr <= imem_rdata;
                end else begin
                    pc_out          <= pc + PC_STEP;
                    instruction_out <= imem_rdata;
                    valid_out       <= 1'b1;
                end
            end else if (!freeze) begin
                instruction_out <= 32'h0;
                valid_out       <= 1'b0;
            end
        end else if (!freeze) begin
            pc_out          <= hold_pc;
            instruction_out <= hold_instr;
            valid_out       <= 1'b1;
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (accept)                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (imem_req && !imem_ack) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Memory image: each word is tagged with its own address.
    assign imem_rdata = 32'hE000_0000 | imem_addr;

    fetch_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction_out(instruction_out),
        .valid_out(valid_out)
`ifdef IF_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_ack = 1'b0;
        step(); step();
        total++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out got %h want 0", pc_out); else passed++;
        total++; if (instruction_out !== 32'h0) $display("FAIL reset_instr got %h want 0", instruction_out); else passed++;
        total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out); else passed++;
        rst = 1'b1;
        step();
        total++; if (imem_req !== 1'b1) $display("FAIL reset_req got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else passed++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * i);
            total++; if (imem_addr !== a) $display("FAIL zw_addr%0d got %h want %h", i, imem_addr, a); else passed++;
            imem_ack = 1'b1;
            step();
            total++;
            if (pc_out !== a + 32'd4 || valid_out !== 1'b1 || instruction_out !== (32'hE000_0000 | a))
                $display("FAIL zw_out%0d got %h/%h/%b want %h/%h/1", i, pc_out, instruction_out, valid_out,
                         a + 32'd4, 32'hE000_0000 | a);
            else passed++;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_latency();
        logic [31:0] a;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            a = 32'(4 * f);
            for (int c = 0; c < 3; c++) begin
                imem_ack = (c == 2);
                step();
                total++;
                if (c < 2) begin
                    if (valid_out !== 1'b0 || instruction_out !== 32'h0 || imem_addr !== a)
                        $display("FAIL lat_bubble%0d_%0d got %b/%h/%h want 0/0/%h", f, c, valid_out,
                                 instruction_out, imem_addr, a);
                    else passed++;
                end else begin
                    if (valid_out !== 1'b1 || pc_out !== a + 32'd4 || instruction_out !== (32'hE000_0000 | a))
                        $display("FAIL lat_fetch%0d got %b/%h/%h want 1/%h", f, valid_out, pc_out,
                                 instruction_out, a + 32'd4);
                    else passed++;
                end
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        imem_ack = 1'b1;
        step();                              // addr 0 delivered, pc_out = 4
        freeze = 1'b1;                       // ack for addr 4 lands in hold
        step();
        imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (imem_req !== 1'b0 || pc_out !== 32'h4 || valid_out !== 1'b1 || instruction_out !== 32'hE000_0000)
                $display("FAIL frz_hold%0d got %b/%h/%b/%h want 0/4/1/e0000000", k, imem_req, pc_out,
                         valid_out, instruction_out);
            else passed++;
            if (k == 0) step();
        end
        freeze = 1'b0;
        step();
        total++;
        if (pc_out !== 32'h8 || valid_out !== 1'b1 || instruction_out !== 32'hE000_0004)
            $display("FAIL frz_release got %h/%b/%h want 8/1/e0000004", pc_out, valid_out, instruction_out);
        else passed++;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8)
            $display("FAIL frz_next_req got %b/%h want 1/8", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_branch_kill();
        do_reset();
        imem_ack = 1'b1;
        step(); step();                      // addr now 8
        imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
        step();
        branch_taken = 1'b0;
        total++;
        if (imem_addr !== 32'h8 || imem_req !== 1'b1 || valid_out !== 1'b0 || instruction_out !== 32'h0)
            $display("FAIL br_kill got %h/%b/%b/%h want 8/1/0/0", imem_addr, imem_req, valid_out, instruction_out);
        else passed++;
        step();
        total++; if (imem_addr !== 32'h8) $display("FAIL br_addr_stable got %h want 8", imem_addr); else passed++;
        imem_ack = 1'b1;
        step();                              // killed data dropped
        total++;
        if (valid_out !== 1'b0 || instruction_out !== 32'h0 || imem_addr !== 32'h100)
            $display("FAIL br_discard got %b/%h/%h want 0/0/100", valid_out, instruction_out, imem_addr);
        else passed++;
        step();
        total++;
        if (pc_out !== 32'h104 || valid_out !== 1'b1 || instruction_out !== 32'hE000_0100)
            $display("FAIL br_target got %h/%b/%h want 104/1/e0000100", pc_out, valid_out, instruction_out);
        else passed++;
        imem_ack = 1'b0;
    endtask

    task automatic test_branch_wrap();
        do_reset();
        imem_ack = 1'b1; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step();                              // same-cycle ack discarded, no kill
        branch_taken = 1'b0;
        total++;
        if (valid_out !== 1'b0 || imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_redirect got %b/%h want 0/fffffffc", valid_out, imem_addr);
        else passed++;
        step();
        total++;
        if (pc_out !== 32'h0 || valid_out !== 1'b1 || instruction_out !== 32'hFFFF_FFFC)
            $display("FAIL wrap_out got %h/%b/%h want 0/1/fffffffc", pc_out, valid_out, instruction_out);
        else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h want 0", imem_addr); else passed++;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        // reset while a killed request is outstanding
        do_reset();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h200;
        step();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 32'h4) $display("FAIL rk_killed got %h want 4", imem_addr); else passed++;
        rst = 1'b0;
        step();
        total++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL rk_reset got %h/%b/%b want 0/1/0", imem_addr, imem_req, valid_out);
        else passed++;
        rst = 1'b1; imem_ack = 1'b1;
        step();                              // kill cleared: this ack is real
        total++;
        if (valid_out !== 1'b1 || pc_out !== 32'h4 || instruction_out !== 32'hE000_0000)
            $display("FAIL rk_after got %b/%h/%h want 1/4/e0000000", valid_out, pc_out, instruction_out);
        else passed++;
        // reset while hold buffer is full
        do_reset();
        freeze = 1'b1; imem_ack = 1'b1;
        step();
        total++; if (imem_req !== 1'b0) $display("FAIL rf_full got %b want 0", imem_req); else passed++;
        rst = 1'b0; imem_ack = 1'b0;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL rf_reset got %b/%h want 1/0", imem_req, imem_addr);
        else passed++;
        rst = 1'b1; freeze = 1'b0;
        step();
        total++;
        if (valid_out !== 1'b0 || instruction_out !== 32'h0)
            $display("FAIL rf_hold_empty got %b/%h want 0/0", valid_out, instruction_out);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_freeze();
        test_branch_kill();
        test_branch_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
